// File: rtl/cpu_out_disp_pkg.sv
// Shared types and constants for the CPU OUT-port hex display.
package cpu_out_disp_pkg;

    localparam int DIGITS = 8;

    typedef logic [6:0] seg_t;
    typedef logic [2:0] digit_idx_t;

    // All segments off (active-low).
    localparam seg_t SEG_BLANK = 7'h7F;

    // Active-low {g,f,e,d,c,b,a} patterns for hex digits 0..F.
    localparam seg_t HEX7_LUT [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30,
        7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03,
        7'h46, 7'h21, 7'h06, 7'h0E
    };

    // Bit offset of the nibble shown on a given digit.
    function automatic logic [4:0] nibble_lsb(input digit_idx_t idx);
        return {idx, 2'b00};
    endfunction

endpackage

// File: rtl/hex7seg_decoder.sv
// Nibble to active-low seven-segment pattern, with a blank override.
module hex7seg_decoder
    import cpu_out_disp_pkg::*;
(
    input  logic [3:0] nib_i,
    input  logic       blank_i,
    output seg_t       seg_o
);

    // Blank wins over the nibble value.
    always_comb begin
        seg_o = HEX7_LUT[nib_i];
        if (blank_i) begin
            seg_o = SEG_BLANK;
        end
    end

endmodule

// File: rtl/cpu_out_hex_display.sv
// Eight-digit multiplexed hex display of the core's OUT port.
// OUT is captured into a shadow register once per scan frame so a frame
// never shows a mix of two values; the decimal point on digit 0 flags a
// frame whose value differs from the previous one.
// Optional build macro CPU_OUT_DISP_LZ_BLANK_EN enables leading-zero blanking.
module cpu_out_hex_display
    import cpu_out_disp_pkg::*;
#(
    parameter int REFRESH_DIV = 50000
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [31:0]       out_i,
    input  logic              hold_i,
    output logic [DIGITS-1:0] an_o,
    output seg_t              seg_o,
    output logic              dp_o
);

    localparam logic [19:0] DIV_LAST = 20'(REFRESH_DIV - 1);

    logic [19:0] div_cnt_q, div_cnt_d;
    digit_idx_t  digit_idx_q, digit_idx_d;
    logic [31:0] shadow_q, shadow_d;
    logic [31:0] prev_shadow_q, prev_shadow_d;
    logic        upd_flag_q, upd_flag_d;

    logic        tick;
    logic        frame_start;
    logic [3:0]  cur_nibble;
    logic        lz_blank;

    // Refresh divider, digit scan and once-per-frame capture.
    always_comb begin
        tick        = (div_cnt_q == DIV_LAST);
        frame_start = (div_cnt_q == 20'd0) && (digit_idx_q == '0);

        div_cnt_d     = tick ? 20'd0 : div_cnt_q + 20'd1;
        digit_idx_d   = tick ? digit_idx_q + 3'd1 : digit_idx_q;
        shadow_d      = shadow_q;
        prev_shadow_d = prev_shadow_q;
        upd_flag_d    = upd_flag_q;

        if (frame_start) begin
            if (!hold_i) begin
                prev_shadow_d = shadow_q;
                shadow_d      = out_i;
                upd_flag_d    = (out_i != shadow_q);
            end else begin
                upd_flag_d    = 1'b0;
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            div_cnt_q     <= 20'd0;
            digit_idx_q   <= '0;
            shadow_q      <= 32'd0;
            prev_shadow_q <= 32'd0;
            upd_flag_q    <= 1'b0;
        end else begin
            div_cnt_q     <= div_cnt_d;
            digit_idx_q   <= digit_idx_d;
            shadow_q      <= shadow_d;
            prev_shadow_q <= prev_shadow_d;
            upd_flag_q    <= upd_flag_d;
        end
    end

    assign cur_nibble = shadow_q[nibble_lsb(digit_idx_q) +: 4];

`ifdef CPU_OUT_DISP_LZ_BLANK_EN
    // A digit is a leading zero when it and every digit above it are zero.
    assign lz_blank = (digit_idx_q != '0) &&
                      ((shadow_q >> nibble_lsb(digit_idx_q)) == 32'd0);
`else
    assign lz_blank = 1'b0;
`endif

    hex7seg_decoder u_dec (
        .nib_i   (cur_nibble),
        .blank_i (lz_blank),
        .seg_o   (seg_o)
    );

    // Pins decode only registered state; no combinational path from out_i.
    assign an_o = ~(DIGITS'(1) << digit_idx_q);
    assign dp_o = ~(upd_flag_q && (digit_idx_q == '0));

endmodule

// File: tb/tb_cpu_out_hex_display.sv
// Bench for cpu_out_hex_display with REFRESH_DIV=4 (32-cycle frames).
module tb_cpu_out_hex_display;

    localparam int RD    = 4;
    localparam int FRAME = 8 * RD;
`ifdef CPU_OUT_DISP_LZ_BLANK_EN
    localparam bit LZ = 1'b1;
`else
    localparam bit LZ = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        hold = 1'b0;
    logic [31:0] out_v = 32'd0;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp;

    always #5 clk = ~clk;

    cpu_out_hex_display #(.REFRESH_DIV(RD)) dut (
        .clk_i  (clk),
        .rst_i  (rst),
        .out_i  (out_v),
        .hold_i (hold),
        .an_o   (an),
        .seg_o  (seg),
        .dp_o   (dp)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference: time since reset plus the value captured at each frame start.
    int          m_t   = 0;
    logic [31:0] m_sh  = 32'd0;
    bit          m_upd = 1'b0;

    logic [6:0] ref_lut [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    typedef struct {
        logic        rst;
        logic        hold;
        logic [31:0] out;
        int          n;
        logic [7:0]  an;
        logic [6:0]  seg;
        logic        dp;
    } vec_t;

    vec_t vt [11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at t=%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    function automatic int cur_digit();
        return (m_t / RD) % 8;
    endfunction

    function automatic logic [6:0] model_seg();
        int d;
        logic [31:0] upper;
        logic [3:0] nib;
        d     = cur_digit();
        upper = m_sh >> (4 * d);
        nib   = upper[3:0];
        if (LZ && d != 0 && upper == 32'd0) return 7'h7F;
        return ref_lut[nib];
    endfunction

    task automatic model_step();
        if (rst) begin
            m_t   = 0;
            m_sh  = 32'd0;
            m_upd = 1'b0;
        end else begin
            if (m_t % FRAME == 0) begin
                if (!hold) begin
                    m_upd = (out_v != m_sh);
                    m_sh  = out_v;
                end else begin
                    m_upd = 1'b0;
                end
            end
            m_t++;
        end
    endtask

    // One clock: advance the model with the inputs the DUT will sample, then compare.
    task automatic tick();
        int d;
        model_step();
        @(posedge clk);
        #1;
        d = cur_digit();
        check("an", {24'd0, an}, {24'd0, 8'hFF ^ (8'h01 << d)});
        check("seg", {25'd0, seg}, {25'd0, model_seg()});
        check("dp", {31'd0, dp}, {31'd0, !(m_upd && d == 0)});
    endtask

    task automatic goto_pos(input int p);
        for (int i = 0; i < FRAME && (m_t % FRAME) != p; i++) tick();
    endtask

    initial begin
        logic [6:0] z;
        z = LZ ? 7'h7F : 7'h40;
        vt[0]  = '{1'b1, 1'b0, 32'h0,  1, 8'hFE, 7'h40, 1'b1};
        vt[1]  = '{1'b0, 1'b0, 32'h0,  1, 8'hFE, 7'h40, 1'b1};
        vt[2]  = '{1'b0, 1'b0, 32'h0,  3, 8'hFD, z,     1'b1};
        vt[3]  = '{1'b0, 1'b0, 32'h0,  4, 8'hFB, z,     1'b1};
        vt[4]  = '{1'b0, 1'b0, 32'h0, 20, 8'h7F, z,     1'b1};
        vt[5]  = '{1'b0, 1'b0, 32'h0,  4, 8'hFE, 7'h40, 1'b1};
        vt[6]  = '{1'b0, 1'b0, 32'hF8, 1, 8'hFE, 7'h00, 1'b0};
        vt[7]  = '{1'b0, 1'b0, 32'hF8, 3, 8'hFD, 7'h0E, 1'b1};
        vt[8]  = '{1'b0, 1'b0, 32'hF8, 4, 8'hFB, z,     1'b1};
        vt[9]  = '{1'b0, 1'b0, 32'hF8, 24, 8'hFE, 7'h00, 1'b0};
        vt[10] = '{1'b0, 1'b0, 32'hF8, 1, 8'hFE, 7'h00, 1'b1};

        for (int v = 0; v < 11; v++) begin
            rst   = vt[v].rst;
            hold  = vt[v].hold;
            out_v = vt[v].out;
            for (int c = 0; c < vt[v].n; c++) tick();
            check($sformatf("vec%0d_an", v), {24'd0, an}, {24'd0, vt[v].an});
            check($sformatf("vec%0d_seg", v), {25'd0, seg}, {25'd0, vt[v].seg});
            check($sformatf("vec%0d_dp", v), {31'd0, dp}, {31'd0, vt[v].dp});
        end

        // No tearing: a mid-frame change waits for the next frame.
        goto_pos(0);
        out_v = 32'h12345678;
        tick();
        goto_pos(10);
        out_v = 32'hAAAAAAAA;
        goto_pos(12);
        check("tear_an_d3", {24'd0, an}, 32'hF7);
        check("tear_seg_d3", {25'd0, seg}, 32'h12);
        goto_pos(28);
        check("tear_seg_d7", {25'd0, seg}, 32'h79);
        goto_pos(0);
        check("tear_seg_old_d0", {25'd0, seg}, 32'h00);
        tick();
        check("tear_seg_new_d0", {25'd0, seg}, 32'h08);
        check("tear_dp_new", {31'd0, dp}, 32'h0);

        // Hold: frame-start captures are suppressed for three frames.
        goto_pos(0);
        hold  = 1'b1;
        out_v = 32'hDEADBEEF;
        for (int c = 0; c < 3 * FRAME; c++) begin
            tick();
            check("hold_seg", {25'd0, seg}, 32'h08);
            check("hold_dp", {31'd0, dp}, 32'h1);
        end
        hold = 1'b0;
        goto_pos(0);
        tick();
        check("hold_rel_seg", {25'd0, seg}, 32'h0E);
        check("hold_rel_dp", {31'd0, dp}, 32'h0);

        // Reset mid-frame while digit 5 is lit.
        goto_pos(20);
        check("mid_an_d5", {24'd0, an}, 32'hDF);
        rst   = 1'b1;
        out_v = 32'h00000003;
        tick();
        check("mid_rst_an", {24'd0, an}, 32'hFE);
        check("mid_rst_seg", {25'd0, seg}, 32'h40);
        check("mid_rst_dp", {31'd0, dp}, 32'h1);
        rst = 1'b0;
        tick();
        check("mid_rel_seg", {25'd0, seg}, 32'h30);
        check("mid_rel_dp", {31'd0, dp}, 32'h0);
        tick();
        tick();
        tick();
        check("mid_rel_an_d1", {24'd0, an}, 32'hFD);

        // Randomised run against the reference model.
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 7) == 0)
                out_v = $urandom() >> $urandom_range(0, 31);
            hold = ($urandom_range(0, 9) == 0);
            rst  = ($urandom_range(0, 199) == 0);
            tick();
        end
        rst  = 1'b0;
        hold = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
